serial_tx_reg: RTL and testbench

- Parallel-in, serial-out transmit register. The counterpart of the team's parallel load registers.
- Captures a WIDTH-bit word through a ready/load handshake, then shifts it out MSB first on a generated serial clock. It ends each word with a latch strobe.
- Drives serial-input display/LCD shift chains (74HC164/595-style) in the Storage/Reg area.

---
 rtl/serial_tx_reg.sv | 114 +++++++++++
 tb/tb_serial_tx_reg.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_reg.sv
// Parallel-in, serial-out transmit register: accepts a word on ready/load,
// shifts it out MSB first on a divided sclk, then strobes latch and pulses done.
module serial_tx_reg #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             sclk,
  output logic             sdat,
  output logic             latch,
  output logic             done
);

  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOW   = 2'd1,
    HIGH  = 2'd2,
    LATCH = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic [DW-1:0]    div_cnt;
  logic             div_end_c;
  logic [WIDTH-1:0] shreg_nxt_c;

  // Phase boundary and the word after one left shift (next bit sits in the MSB).
  assign div_end_c   = (div_cnt == DIV_LAST);
  assign shreg_nxt_c = shreg << 1;

  // Single-process FSM; every output is a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ready   <= 1'b1;
      sclk    <= 1'b0;
      sdat    <= 1'b0;
      latch   <= 1'b0;
      done    <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (load) begin
            shreg   <= din;
            sdat    <= din[WIDTH-1];
            bit_cnt <= BIT_LAST;
            div_cnt <= '0;
            ready   <= 1'b0;
            state   <= LOW;
          end
        end

        LOW: begin
          if (div_end_c) begin
            sclk    <= 1'b1;
            div_cnt <= '0;
            state   <= HIGH;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end

        // Falling sclk edge: data only moves while the receiver is not sampling.
        HIGH: begin
          if (div_end_c) begin
            sclk    <= 1'b0;
            div_cnt <= '0;
            if (bit_cnt == '0) begin
              sdat  <= 1'b0;
              latch <= 1'b1;
              state <= LATCH;
            end else begin
              shreg   <= shreg_nxt_c;
              sdat    <= shreg_nxt_c[WIDTH-1];
              bit_cnt <= bit_cnt - BW'(1);
              state   <= LOW;
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end

        LATCH: begin
          if (div_end_c) begin
            latch   <= 1'b0;
            done    <= 1'b1;
            ready   <= 1'b1;
            div_cnt <= '0;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_reg.sv
// Bench for serial_tx_reg: two instances (8-bit/div4 and 4-bit/div1) checked every
// cycle against a timing-formula model, plus a serial receiver scoreboard per word.
module tb_serial_tx_reg;

  localparam int unsigned WA = 8;
  localparam int unsigned CA = 4;
  localparam int unsigned WB = 4;
  localparam int unsigned CB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a, load_a, ready_a, sclk_a, sdat_a, latch_a, done_a;
  logic [WA-1:0] din_a;
  logic          rst_b, load_b, ready_b, sclk_b, sdat_b, latch_b, done_b;
  logic [WB-1:0] din_b;

  serial_tx_reg #(.WIDTH(WA), .CLK_DIV(CA)) dut_a (
    .clk(clk), .rst(rst_a), .din(din_a), .load(load_a), .ready(ready_a),
    .sclk(sclk_a), .sdat(sdat_a), .latch(latch_a), .done(done_a)
  );

  serial_tx_reg #(.WIDTH(WB), .CLK_DIV(CB)) dut_b (
    .clk(clk), .rst(rst_b), .din(din_b), .load(load_b), .ready(ready_b),
    .sclk(sclk_b), .sdat(sdat_b), .latch(latch_b), .done(done_b)
  );

  int vec = 0;
  int err = 0;
  bit chk_en = 1'b0;

  // Reference model: a word occupies (2W+1)*CD cycles after acceptance.
  int         busy   [2];
  int         jj     [2];
  int         acc    [2];
  logic       done_m [2];
  logic [7:0] word   [2];
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  // Receiver side of the scoreboard.
  logic [7:0] rx     [2];
  int         rxn    [2];
  logic       psclk  [2];
  logic       platch [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      busy[i] = 0; jj[i] = 0; acc[i] = 0; done_m[i] = 1'b0; word[i] = '0;
      rx[i] = '0; rxn[i] = 0; psclk[i] = 1'b0; platch[i] = 1'b0;
    end
  end

  function automatic int wd(input int i);
    return (i == 0) ? int'(WA) : int'(WB);
  endfunction

  function automatic int cdv(input int i);
    return (i == 0) ? int'(CA) : int'(CB);
  endfunction

  task automatic step(input int i, input logic r, input logic ld, input logic [7:0] d);
    int t;
    t = (2 * wd(i) + 1) * cdv(i);
    if (r) begin
      busy[i] = 0; jj[i] = 0; done_m[i] = 1'b0;
      rx[i] = '0; rxn[i] = 0; psclk[i] = 1'b0; platch[i] = 1'b0;
      if (i == 0) q0.delete(); else q1.delete();
    end else if (busy[i] == 0) begin
      done_m[i] = 1'b0;
      if (ld) begin
        busy[i] = 1; jj[i] = 0; word[i] = d; acc[i]++;
        if (i == 0) q0.push_back(d); else q1.push_back(d);
      end
    end else begin
      jj[i]++;
      if (jj[i] == t) begin
        busy[i] = 0;
        done_m[i] = 1'b1;
      end
    end
  endtask

  always @(posedge clk) begin
    step(0, rst_a, load_a, 8'(din_a));
    step(1, rst_b, load_b, 8'(din_b));
  end

  task automatic cmp(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", nm, i, $time, act, exp);
    end
  endtask

  task automatic mon(input int i, input logic rdy, input logic sc, input logic sd,
                     input logic la, input logic dn);
    int w, c, span;
    logic e_sc, e_sd, e_la;
    logic [7:0] ew;
    w = wd(i); c = cdv(i); span = 2 * w * c;
    e_sc = 1'b0; e_sd = 1'b0; e_la = 1'b0;
    if (busy[i] != 0) begin
      e_la = (jj[i] >= span);
      e_sc = (jj[i] < span) && (((jj[i] / c) % 2) == 1);
      if (jj[i] < span) e_sd = word[i][w - 1 - jj[i] / (2 * c)];
    end
    cmp("ready", i, 32'(rdy), 32'(busy[i] == 0));
    cmp("sclk",  i, 32'(sc),  32'(e_sc));
    cmp("sdat",  i, 32'(sd),  32'(e_sd));
    cmp("latch", i, 32'(la),  32'(e_la));
    cmp("done",  i, 32'(dn),  32'(done_m[i]));
    if (sc && !psclk[i]) begin
      rx[i] = {rx[i][6:0], sd};
      rxn[i]++;
    end
    if (la && !platch[i]) begin
      if (((i == 0) ? q0.size() : q1.size()) == 0) begin
        vec++; err++;
        $display("FAIL rxword[%0d] at %0t: latch with no word outstanding", i, $time);
      end else begin
        ew = (i == 0) ? q0.pop_front() : q1.pop_front();
        cmp("rxbits", i, 32'(rxn[i]), 32'(w));
        cmp("rxword", i, 32'(rx[i]), 32'(ew));
      end
      rx[i] = '0; rxn[i] = 0;
    end
    psclk[i] = sc;
    platch[i] = la;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      mon(0, ready_a, sclk_a, sdat_a, latch_a, done_a);
      mon(1, ready_b, sclk_b, sdat_b, latch_b, done_b);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while (busy[i] != 0 && n < 1000) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_acc(input int i, input int target);
    int n;
    n = 0;
    while (acc[i] < target && n < 1000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    rst_a = 1'b1; load_a = 1'b0; din_a = '0;
    rst_b = 1'b1; load_b = 1'b0; din_b = '0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    fork
      begin : seq_a
        int a0;
        tick();
        rst_a = 1'b0;
        repeat (10) tick();
        // Single word, then load pulses / din changes while busy.
        din_a = 8'hA5; load_a = 1'b1; tick(); load_a = 1'b0; din_a = 8'($urandom);
        wait_idle(0);
        // Back-to-back words with load held high.
        a0 = acc[0];
        din_a = 8'hFF; load_a = 1'b1; tick(); din_a = 8'h00;
        wait_acc(0, a0 + 2);
        load_a = 1'b0;
        wait_idle(0);
        din_a = 8'h3C; load_a = 1'b1; tick(); load_a = 1'b0;
        repeat (9) tick();
        din_a = 8'hC3; load_a = 1'b1; tick(); load_a = 1'b0;
        wait_idle(0);
        // Reset mid-transfer, then a fresh word.
        din_a = 8'($urandom); load_a = 1'b1; tick(); load_a = 1'b0;
        repeat (19) tick();
        rst_a = 1'b1; tick(); rst_a = 1'b0;
        din_a = 8'h81; load_a = 1'b1; tick(); load_a = 1'b0;
        wait_idle(0);
        repeat (1500) begin
          load_a = ($urandom_range(0, 3) == 0);
          din_a  = 8'($urandom);
          rst_a  = ($urandom_range(0, 299) == 0);
          tick();
        end
        rst_a = 1'b0; load_a = 1'b0;
        wait_idle(0);
        repeat (3) tick();
      end
      begin : seq_b
        tick();
        rst_b = 1'b0;
        repeat (3) tick();
        din_b = 4'b1001; load_b = 1'b1; tick(); load_b = 1'b0;
        wait_idle(1);
        repeat (400) begin
          load_b = ($urandom_range(0, 2) == 0);
          din_b  = 4'($urandom);
          rst_b  = ($urandom_range(0, 199) == 0);
          tick();
        end
        rst_b = 1'b0; load_b = 1'b0;
        wait_idle(1);
        repeat (3) tick();
      end
    join
    cmp("pending", 0, 32'(q0.size()), 32'(0));
    cmp("pending", 1, 32'(q1.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
